// File: rtl/spwtcr_link_fsm.sv
// SpwTCR SpaceWire link-initialisation state machine: sequences
// ErrorReset -> ErrorWait -> Ready -> Started -> Connecting -> Run.
//
// Ports:
//   CLOCK, RESETn        clock, async active-low reset
//   linkStart            host level: start the link
//   linkDisable          host level: hold the link down
//   autoStart            host level: start on first NULL received
//                        (used only with SPWTCR_LINK_AUTOSTART_EN)
//   after64, after128    FSM timer timeout pulses
//   gotNULL, gotFCT      receiver event pulses
//   gotNChar, gotTimeCode
//   rxError              disconnect/parity/escape error pulse
//   creditError          credit-overflow pulse
//   enableTimer          timer run enable (low clears the timer)
//   enableRx, enableTx   receiver/transmitter enables
//   sendNULLs, sendFCTs  transmitter permissions
//   sendNChars
//   linkState            state code (0..5)
//   linkRunning          high in Run
//
// Configuration macro: SPWTCR_LINK_AUTOSTART_EN enables autoStart.

module spwtcr_link_fsm (
   input  logic       CLOCK,
   input  logic       RESETn,
   input  logic       linkStart,
   input  logic       linkDisable,
   input  logic       autoStart,
   input  logic       after64,
   input  logic       after128,
   input  logic       gotNULL,
   input  logic       gotFCT,
   input  logic       gotNChar,
   input  logic       gotTimeCode,
   input  logic       rxError,
   input  logic       creditError,
   output logic       enableTimer,
   output logic       enableRx,
   output logic       enableTx,
   output logic       sendNULLs,
   output logic       sendFCTs,
   output logic       sendNChars,
   output logic [2:0] linkState,
   output logic       linkRunning
);

   typedef enum logic [2:0] {
      ST_ERROR_RESET = 3'd0,
      ST_ERROR_WAIT  = 3'd1,
      ST_READY       = 3'd2,
      ST_STARTED     = 3'd3,
      ST_CONNECTING  = 3'd4,
      ST_RUN         = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic timer_en_q, timer_en_d;
   logic rx_en_q, rx_en_d;
   logic tx_en_q, tx_en_d;
   logic nulls_q, nulls_d;
   logic fcts_q, fcts_d;
   logic nchars_q, nchars_d;
   logic running_q, running_d;
   logic null_seen_q, null_seen_d;

   logic link_en;
   logic tmo64;
   logic tmo128;
   logic rx_err_any;
   logic state_chg;

   // Timeouts only count while the timer was actually running; a
   // pulse in the clearing cycle is stale from the previous state.
   assign tmo64  = after64  & timer_en_q;
   assign tmo128 = after128 & timer_en_q;

   // Errors before Connecting: any non-NULL character is a protocol
   // violation, as is a receiver error.
   assign rx_err_any = rxError | gotFCT | gotNChar | gotTimeCode;

`ifdef SPWTCR_LINK_AUTOSTART_EN
   assign link_en = !linkDisable &&
                    (linkStart || (autoStart && null_seen_q));
`else
   logic unused_autostart;
   assign unused_autostart = autoStart;
   assign link_en = !linkDisable && linkStart;
`endif

   // Next-state logic: error, then progress, then timeout.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_ERROR_RESET: begin
            if (tmo64)
               state_d = ST_ERROR_WAIT;
         end
         ST_ERROR_WAIT: begin
            if (rx_err_any)
               state_d = ST_ERROR_RESET;
            else if (tmo128)
               state_d = ST_READY;
         end
         ST_READY: begin
            if (rx_err_any)
               state_d = ST_ERROR_RESET;
            else if (link_en)
               state_d = ST_STARTED;
         end
         ST_STARTED: begin
            if (rx_err_any)
               state_d = ST_ERROR_RESET;
            else if (null_seen_q || gotNULL)
               state_d = ST_CONNECTING;
            else if (tmo128)
               state_d = ST_ERROR_RESET;
         end
         ST_CONNECTING: begin
            if (rxError || gotNChar || gotTimeCode)
               state_d = ST_ERROR_RESET;
            else if (gotFCT)
               state_d = ST_RUN;
            else if (tmo128)
               state_d = ST_ERROR_RESET;
         end
         ST_RUN: begin
            if (rxError || creditError || linkDisable)
               state_d = ST_ERROR_RESET;
         end
         default: state_d = ST_ERROR_RESET;
      endcase
   end

   // Output decode from the next state so that every output is a
   // register aligned with linkState.
   assign state_chg = (state_d != state_q);

   always_comb begin
      timer_en_d = 1'b0;
      rx_en_d    = 1'b0;
      tx_en_d    = 1'b0;
      nulls_d    = 1'b0;
      fcts_d     = 1'b0;
      nchars_d   = 1'b0;
      running_d  = 1'b0;

      rx_en_d = (state_d != ST_ERROR_RESET);

      if (state_d inside {ST_STARTED, ST_CONNECTING, ST_RUN}) begin
         tx_en_d = 1'b1;
         nulls_d = 1'b1;
      end

      if (state_d inside {ST_CONNECTING, ST_RUN})
         fcts_d = 1'b1;

      if (state_d == ST_RUN) begin
         nchars_d  = 1'b1;
         running_d = 1'b1;
      end

      // A one-cycle low pulse on any transition restarts the timer.
      if (!state_chg)
         timer_en_d = state_d inside {ST_ERROR_RESET, ST_ERROR_WAIT,
                                      ST_STARTED, ST_CONNECTING};
   end

   // NULL latch: only meaningful while the receiver is enabled.
   always_comb begin
      null_seen_d = null_seen_q;
      if (state_q == ST_ERROR_RESET)
         null_seen_d = 1'b0;
      else if (gotNULL && rx_en_q)
         null_seen_d = 1'b1;
   end

   always_ff @(posedge CLOCK or negedge RESETn) begin
      if (!RESETn) begin
         state_q     <= ST_ERROR_RESET;
         timer_en_q  <= 1'b0;
         rx_en_q     <= 1'b0;
         tx_en_q     <= 1'b0;
         nulls_q     <= 1'b0;
         fcts_q      <= 1'b0;
         nchars_q    <= 1'b0;
         running_q   <= 1'b0;
         null_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_en_q  <= timer_en_d;
         rx_en_q     <= rx_en_d;
         tx_en_q     <= tx_en_d;
         nulls_q     <= nulls_d;
         fcts_q      <= fcts_d;
         nchars_q    <= nchars_d;
         running_q   <= running_d;
         null_seen_q <= null_seen_d;
      end
   end

   assign linkState   = state_q;
   assign enableTimer = timer_en_q;
   assign enableRx    = rx_en_q;
   assign enableTx    = tx_en_q;
   assign sendNULLs   = nulls_q;
   assign sendFCTs    = fcts_q;
   assign sendNChars  = nchars_q;
   assign linkRunning = running_q;

endmodule
